// File: rtl/posit_pkg.sv
// Shared posit format definitions used by the posit FPU datapath.
package posit_pkg;

  typedef enum logic [1:0] {
    Posit32 = 2'd0,
    Posit16 = 2'd1,
    Posit8  = 2'd2,
    Posit64 = 2'd3
  } posit_format_e;

  function automatic int unsigned posit_width(posit_format_e fmt);
    int unsigned w;
    case (fmt)
      Posit16: w = 16;
      Posit8:  w = 8;
      Posit64: w = 64;
      default: w = 32;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/posit_encoder.sv
// Posit encoder: packs sign/scale/mantissa/sticky/special flags into a rounded posit word.
// Two-stage elastic pipeline: stage 1 splits scale into regime/exponent and checks saturation,
// stage 2 builds the body, rounds to nearest even and applies sign and specials.
module posit_encoder #(
  parameter posit_pkg::posit_format_e pFormat = posit_pkg::posit_format_e'(0),
  parameter int unsigned ES      = 2,
  parameter int unsigned MAN_W   = 28,
  parameter int unsigned SCALE_W = 10,
  parameter int unsigned TAG_W   = 1,
  localparam int unsigned N      = posit_pkg::posit_width(pFormat)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               sign_i,
  input  logic [SCALE_W-1:0] scale_i,
  input  logic [MAN_W-1:0]   mant_i,
  input  logic               sticky_i,
  input  logic               is_zero_i,
  input  logic               is_nar_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [N-1:0]       posit_o,
  output logic [TAG_W-1:0]   tag_o
);

  localparam int unsigned FRAC_W = MAN_W - 1;
  // Terminating regime bit, exponent and fraction, placed after the regime run.
  localparam int unsigned REM_W  = 1 + ES + FRAC_W;
  // Wide enough for the longest regime run plus everything behind it, so every input bit
  // reaches either the body, the guard or the sticky OR.
  localparam int unsigned SH_W   = N + ES + MAN_W;
  localparam int unsigned DROP_W = SH_W - N;
  localparam int          SAT    = int'((N - 2) << ES);

  typedef struct packed {
    logic                      sign;
    logic signed [SCALE_W-1:0] k;
    logic [ES-1:0]             e;
    logic [FRAC_W-1:0]         frac;
    logic                      sticky;
    logic                      zero;
    logic                      nar;
    logic                      sat_max;
    logic                      sat_min;
    logic [TAG_W-1:0]          tag;
  } s1_t;

  s1_t                s1_d, s1_q;
  logic               s1_valid_d, s1_valid_q;
  logic               s2_valid_d, s2_valid_q;
  logic [N-1:0]       posit_d, posit_q;
  logic [TAG_W-1:0]   tag_d, tag_q;

  logic               s1_advance;
  logic               in_fire;
  logic               unused_hidden;

  logic signed [SCALE_W-1:0] scale_s;
  logic signed [SCALE_W-1:0] k_in;

  logic               k_neg;
  logic [SCALE_W-1:0] run;
  logic [REM_W-1:0]   rem;
  logic [SH_W-1:0]    base;
  logic [SH_W-1:0]    fill_mask;
  logic [SH_W-1:0]    shifted;
  logic [N-2:0]       body;
  logic               guard;
  logic               st;
  logic [N-1:0]       sum;
  logic [N-2:0]       body_r;
  logic [N-1:0]       mag;
  logic [N-1:0]       enc;

  // The hidden bit is implied by normalisation and never stored.
  assign unused_hidden = mant_i[MAN_W-1];

  // Handshake: stage 1 may drain whenever stage 2 is empty or being popped.
  always_comb begin
    s1_advance  = !s2_valid_q || out_ready_i;
    in_ready_o  = !s1_valid_q || s1_advance;
    in_fire     = in_valid_i && in_ready_o;
    out_valid_o = s2_valid_q;
    posit_o     = posit_q;
    tag_o       = tag_q;
  end

  // Stage 1: split scale into regime k and exponent e, flag saturation.
  always_comb begin
    scale_s = signed'(scale_i);
    k_in    = scale_s >>> ES;
    s1_d    = s1_q;
    if (in_fire) begin
      s1_d.sign    = sign_i;
      s1_d.k       = k_in;
      s1_d.e       = scale_i[ES-1:0];
      s1_d.frac    = mant_i[FRAC_W-1:0];
      s1_d.sticky  = sticky_i;
      s1_d.zero    = is_zero_i;
      s1_d.nar     = is_nar_i;
      s1_d.sat_max = (int'(scale_s) >= SAT);
      s1_d.sat_min = (int'(scale_s) <= -SAT);
      s1_d.tag     = tag_i;
    end
    if (in_fire) begin
      s1_valid_d = 1'b1;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2: build regime|e|frac body, round to nearest even, apply sign and specials.
  always_comb begin
    k_neg = s1_q.k[SCALE_W-1];
    run   = k_neg ? -s1_q.k : s1_q.k + SCALE_W'(1);
    // Terminator is the complement of the run bit: 0 after ones (k >= 0), 1 after zeros.
    rem       = {k_neg, s1_q.e, s1_q.frac};
    base      = {rem, {(SH_W - REM_W){1'b0}}};
    fill_mask = k_neg ? '0 : ~({SH_W{1'b1}} >> run);
    shifted   = (base >> run) | fill_mask;

    body  = shifted[SH_W-1 -: N-1];
    guard = shifted[DROP_W];
    st    = (|shifted[DROP_W-1:0]) | s1_q.sticky;
    sum   = {1'b0, body} + {{(N-1){1'b0}}, guard & (body[0] | st)};

    // Rounding may never reach NaR (carry out) nor zero.
    if (sum[N-1]) begin
      body_r = '1;
    end else begin
      body_r = sum[N-2:0];
    end
    if (body_r == '0) begin
      body_r = {{(N-2){1'b0}}, 1'b1};
    end
    if (s1_q.sat_max) begin
      body_r = '1;
    end else if (s1_q.sat_min) begin
      body_r = {{(N-2){1'b0}}, 1'b1};
    end

    mag = {1'b0, body_r};
    enc = s1_q.sign ? (~mag + {{(N-1){1'b0}}, 1'b1}) : mag;
    if (s1_q.nar) begin
      enc = {1'b1, {(N-1){1'b0}}};
    end else if (s1_q.zero) begin
      enc = '0;
    end

    // Output payload only changes when a new beat is loaded, holding it steady under stall.
    posit_d = posit_q;
    tag_d   = tag_q;
    if (s1_advance && s1_valid_q) begin
      posit_d = enc;
      tag_d   = s1_q.tag;
    end
    s2_valid_d = s1_advance ? s1_valid_q : s2_valid_q;
  end

  // Pipeline registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      posit_q    <= '0;
      tag_q      <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      posit_q    <= posit_d;
      tag_q      <= tag_d;
    end
  end

endmodule

// File: tb/tb_posit_encoder.sv
// Directed bench for posit_encoder (N=32, ES=2, MAN_W=28, SCALE_W=10, TAG_W=1).
module tb_posit_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [9:0]  scale;
  logic [27:0] mant;
  logic        sticky;
  logic        is_zero;
  logic        is_nar;
  logic [0:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] posit;
  logic [0:0]  tag_out;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [27:0] One = 28'h8000000;

  logic [31:0] stream_exp [8] = '{32'h40000000, 32'h48000000, 32'h50000000, 32'h58000000,
                                 32'h60000000, 32'h64000000, 32'h68000000, 32'h6C000000};

  always #5 clk = ~clk;

  posit_encoder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .sign_i      (sign),
    .scale_i     (scale),
    .mant_i      (mant),
    .sticky_i    (sticky),
    .is_zero_i   (is_zero),
    .is_nar_i    (is_nar),
    .tag_i       (tag_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .posit_o     (posit),
    .tag_o       (tag_out)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  // One isolated beat: checks acceptance, exact 2-cycle latency, value and tag.
  task automatic vec(input string name, input logic sg, input logic [9:0] sc,
                     input logic [27:0] mn, input logic stk, input logic z, input logic n,
                     input logic tg, input logic [31:0] exp);
    @(negedge clk);
    sign = sg; scale = sc; mant = mn; sticky = stk; is_zero = z; is_nar = n; tag_in = tg;
    in_valid = 1'b1;
    chk({name, "/in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, "/early_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({name, "/valid"}, 32'(out_valid), 32'd1);
    chk({name, "/posit"}, posit, exp);
    chk({name, "/tag"}, 32'(tag_out), 32'(tg));
  endtask

  initial begin
    int sent, recv, first_cyc, last_cyc;
    logic stalled, fell_checked;
    logic [31:0] held;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sign = 1'b0; scale = '0; mant = One; sticky = 1'b0; is_zero = 1'b0; is_nar = 1'b0;
    tag_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset/out_valid", 32'(out_valid), 32'd0);
    chk("reset/posit", posit, 32'h0);
    chk("reset/tag", 32'(tag_out), 32'd0);
    chk("reset/in_ready", 32'(in_ready), 32'd1);

    // Basic values
    vec("one",      1'b0, 10'd0,   One,          1'b0, 1'b0, 1'b0, 1'b1, 32'h40000000);
    vec("two",      1'b0, 10'd1,   One,          1'b0, 1'b0, 1'b0, 1'b0, 32'h48000000);
    vec("sixteen",  1'b0, 10'd4,   One,          1'b0, 1'b0, 1'b0, 1'b1, 32'h60000000);
    vec("onehalf",  1'b0, 10'd0,   28'hC000000,  1'b0, 1'b0, 1'b0, 1'b0, 32'h44000000);
    vec("neg_one",  1'b1, 10'd0,   One,          1'b0, 1'b0, 1'b0, 1'b1, 32'hC0000000);
    vec("half",     1'b0, -10'sd1, One,          1'b0, 1'b0, 1'b0, 1'b0, 32'h38000000);
    // Specials and saturation
    vec("zero",     1'b1, 10'd5,   28'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h00000000);
    vec("nar",      1'b0, 10'd3,   28'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h80000000);
    vec("sat_max",  1'b0, 10'd200, One,          1'b0, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF);
    vec("sat_min",  1'b0, -10'sd200, One,        1'b0, 1'b0, 1'b0, 1'b0, 32'h00000001);
    vec("neg_max",  1'b1, 10'd200, One,          1'b0, 1'b0, 1'b0, 1'b1, 32'h80000001);
    vec("neg_min",  1'b1, -10'sd200, One,        1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF);
    // Rounding: at scale 4 the fraction lsb is the guard bit
    vec("tie_even", 1'b0, 10'd4,   28'h8000001,  1'b0, 1'b0, 1'b0, 1'b1, 32'h60000000);
    vec("tie_stky", 1'b0, 10'd4,   28'h8000001,  1'b1, 1'b0, 1'b0, 1'b0, 32'h60000001);
    vec("top_rnd",  1'b0, 10'd119, One,          1'b0, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF);

    // Backpressure: 8 beats, out_ready low for cycles 4..8
    sent = 0; recv = 0; stalled = 1'b0; fell_checked = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        chk("bp/hold_valid", 32'(out_valid), 32'd1);
        chk("bp/hold_posit", posit, held);
      end
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid = (sent < 8);
      sign = 1'b0; scale = 10'(sent % 8); mant = One; sticky = 1'b0;
      is_zero = 1'b0; is_nar = 1'b0; tag_in = 1'(sent);
      #4;
      if (in_valid && !in_ready && !fell_checked) begin
        chk("bp/buffered", 32'(sent - recv), 32'd2);
        fell_checked = 1'b1;
      end
      stalled = out_valid && !out_ready;
      held = posit;
      if (out_valid && out_ready) begin
        chk("bp/posit", posit, stream_exp[recv]);
        chk("bp/tag", 32'(tag_out), 32'(recv % 2));
        recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp/count", 32'(recv), 32'd8);
    chk("bp/ready_fell", 32'(fell_checked), 32'd1);

    // Throughput: 16 beats back to back with out_ready high
    sent = 0; recv = 0; first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 40 && recv < 16; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (sent < 16);
      scale = 10'(sent % 8); tag_in = 1'(sent);
      #4;
      if (out_valid) begin
        chk("tp/posit", posit, stream_exp[recv % 8]);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("tp/count", 32'(recv), 32'd16);
    chk("tp/span", 32'(last_cyc - first_cyc), 32'd15);

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; scale = 10'd0;
    @(negedge clk);
    scale = 10'd1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst/full_valid", 32'(out_valid), 32'd1);
    chk("rst/full_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst/out_valid", 32'(out_valid), 32'd0);
    chk("rst/in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst/no_stale", 32'(out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
